// File: rtl/tx_scheduler.sv
// Round-robin scheduler feeding one character at a time from NREQ requesters to a serial transmitter.
// Define TX_SCHED_FIXED_PRIO_EN to switch arbitration to fixed priority (lowest index wins).
module tx_scheduler #(
   parameter int WIDTH        = 8,
   parameter int NREQ         = 4,
   parameter int FRAME_CYCLES = 11
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      en,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]           ack,
   output logic [WIDTH-1:0]          d_in,
   output logic                      d_ready,
   output logic                      tx_en,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   grant_id
);

   // state  | meaning
   // S_IDLE | waiting for en and a request; grant, ack and data capture happen here
   // S_LOAD | d_ready strobe to the transmitter, frame timer loaded
   // S_WAIT | timer counts down to 0, then back to S_IDLE

   localparam int GW = $clog2(NREQ);
   localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  d_in_q, d_in_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     winner;
   logic              found;
   logic [NREQ-1:0]   ack_vec;

`ifdef TX_SCHED_FIXED_PRIO_EN
   always_comb begin : p_arb
      winner = '0;
      found  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            winner = GW'(k);
            found  = 1'b1;
         end
      end
   end
`else
   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin : p_arb
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(grant_q) + 1 + k) % NREQ;
         if (!found && req[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end
`endif

   always_comb begin : p_fsm
      state_d = state_q;
      cnt_d   = cnt_q;
      d_in_d  = d_in_q;
      grant_d = grant_q;
      ack_vec = '0;
      case (state_q)
         S_IDLE: begin
            if (en && found) begin
               ack_vec[winner] = 1'b1;
               d_in_d          = req_data[int'(winner)*WIDTH +: WIDTH];
               grant_d         = winner;
               state_d         = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         d_in_q  <= '0;
         grant_q <= GW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_in_q  <= d_in_d;
         grant_q <= grant_d;
      end
   end

   // ack and tx_en are combinational, so gate them with rstn to keep them low during reset.
   assign ack      = ack_vec & {NREQ{rstn}};
   assign d_ready  = (state_q == S_LOAD);
   assign busy     = (state_q != S_IDLE);
   assign tx_en    = rstn & (en | busy);
   assign d_in     = d_in_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: vector table plus hand-written corner sequences.
// Expected grants and data are queued when stimulus is applied and compared at each d_ready.
module tb_tx_scheduler;

   localparam int WIDTH        = 8;
   localparam int NREQ         = 4;
   localparam int FRAME_CYCLES = 11;
   localparam logic [31:0] DATA_STD = 32'h13121110;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack;
   logic [7:0]  d_in;
   logic        d_ready;
   logic        tx_en;
   logic        busy;
   logic [1:0]  grant_id;

   tx_scheduler #(
      .WIDTH       (WIDTH),
      .NREQ        (NREQ),
      .FRAME_CYCLES(FRAME_CYCLES)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .req     (req),
      .req_data(req_data),
      .ack     (ack),
      .d_in    (d_in),
      .d_ready (d_ready),
      .tx_en   (tx_en),
      .busy    (busy),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0]       req;
      logic [31:0]      data;
      logic             en;
      int               n;
      logic [3:0][1:0]  ids;
   } vec_t;
   vec_t vecs[7];

   int         cyc = 0;
   int         last_ack_cyc = -100;
   int         last_ack_id = -1;
   int         prev_dr = -1;
   int         busy_run = 0;
   int         ack_cnt = 0;
   int         dr_cnt = 0;
   logic [3:0] ack_or = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0][1:0] ids4(input int a, input int b, input int c, input int d);
      logic [3:0][1:0] r;
      r[0] = 2'(a);
      r[1] = 2'(b);
      r[2] = 2'(c);
      r[3] = 2'(d);
      return r;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         busy_run     = 0;
         prev_dr      = -1;
         last_ack_cyc = -100;
      end else begin
         check("tx_en", 32'(tx_en), 32'(en | busy));
         if (ack != 4'b0000) begin
            check("ack_onehot", $countones(ack), 1);
            check("ack_when_idle", 32'(busy), 0);
            for (int i = 0; i < 4; i++) if (ack[i]) last_ack_id = i;
            last_ack_cyc = cyc;
            ack_cnt++;
            ack_or = ack_or | ack;
         end
         if (d_ready) begin
            exp_t e;
            dr_cnt++;
            check("dready_after_ack", cyc - last_ack_cyc, 1);
            if (prev_dr >= 0 && (cyc - prev_dr) <= 15) check("dready_spacing", cyc - prev_dr, 13);
            prev_dr = cyc;
            if (sb.size() == 0) begin
               check("dready_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("grant_idx", last_ack_id, e.id);
               check("grant_id_o", 32'(grant_id), e.id);
               check("d_in", 32'(d_in), 32'(e.data));
            end
         end
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            check("busy_len", busy_run, 12);
            busy_run = 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int id, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.data = data[id*8 +: 8];
      sb.push_back(e);
   endtask

   task automatic do_reset(input logic [3:0] r, input logic [31:0] data, input logic e);
      rstn = 1'b0;
      tick(2);
      req      = r;
      req_data = data;
      en       = e;
      sb.delete();
      ack_cnt = 0;
      dr_cnt  = 0;
      ack_or  = '0;
      rstn    = 1'b1;
   endtask

   task automatic wait_dr(input int n, input int budget);
      int c;
      c = 0;
      while (dr_cnt < n && c < budget) begin
         tick(1);
         c++;
      end
      check("wait_dready", dr_cnt, n);
   endtask

   task automatic run_vec(input vec_t v);
      do_reset(v.req, v.data, v.en);
      for (int k = 0; k < v.n; k++) push(int'(v.ids[k]), v.data);
      if (v.n > 0) wait_dr(v.n, v.n * 13 + 30);
      else tick(30);
      req = '0;
      tick(20);
      check("ack_count", ack_cnt, v.n);
      check("dready_count", dr_cnt, v.n);
      check("sb_empty", sb.size(), 0);
      check("idle_busy", 32'(busy), 0);
      if (v.n > 0) check("d_in_hold", 32'(d_in), 32'(v.data[int'(v.ids[v.n-1])*8 +: 8]));
   endtask

   initial begin
      rstn     = 1'b1;
      en       = 1'b1;
      req      = 4'hF;
      req_data = DATA_STD;
      #1 rstn = 1'b0;
      tick(1);
      check("rst_ack", 32'(ack), 0);
      check("rst_d_ready", 32'(d_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_grant_id", 32'(grant_id), 3);
      check("rst_d_in", 32'(d_in), 0);

      vecs[0] = '{req: 4'b0001, data: 32'h000000A5, en: 1'b1, n: 1, ids: ids4(0, 0, 0, 0)};
      vecs[1] = '{req: 4'b1111, data: DATA_STD, en: 1'b1, n: 4, ids: ids4(0, 1, 2, 3)};
`ifdef TX_SCHED_FIXED_PRIO_EN
      vecs[2] = '{req: 4'b1010, data: DATA_STD, en: 1'b1, n: 4, ids: ids4(1, 1, 1, 1)};
      vecs[4] = '{req: 4'b1001, data: DATA_STD, en: 1'b1, n: 4, ids: ids4(0, 0, 0, 0)};
      vecs[5] = '{req: 4'b0110, data: DATA_STD, en: 1'b1, n: 3, ids: ids4(1, 1, 1, 0)};
`else
      vecs[2] = '{req: 4'b1010, data: DATA_STD, en: 1'b1, n: 4, ids: ids4(1, 3, 1, 3)};
      vecs[4] = '{req: 4'b1001, data: DATA_STD, en: 1'b1, n: 4, ids: ids4(0, 3, 0, 3)};
      vecs[5] = '{req: 4'b0110, data: DATA_STD, en: 1'b1, n: 3, ids: ids4(1, 2, 1, 0)};
`endif
      vecs[3] = '{req: 4'b0100, data: DATA_STD, en: 1'b1, n: 2, ids: ids4(2, 2, 0, 0)};
      vecs[6] = '{req: 4'b1111, data: DATA_STD, en: 1'b0, n: 0, ids: ids4(0, 0, 0, 0)};

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // en dropped mid-frame: frame finishes, then nothing until en returns
      do_reset(4'b0001, DATA_STD, 1'b1);
      push(0, DATA_STD);
      wait_dr(1, 30);
      tick(2);
      en = 1'b0;
      tick(30);
      check("en_low_ack_count", ack_cnt, 1);
      check("en_low_dready_count", dr_cnt, 1);
      check("en_low_busy", 32'(busy), 0);
      check("en_low_tx_en", 32'(tx_en), 0);
      en = 1'b1;
      push(0, DATA_STD);
      wait_dr(2, 30);
      req = '0;
      tick(15);
      check("en_resume_ack_count", ack_cnt, 2);

      // req[2] withdrawn one cycle before its turn; requester 3 must win
      do_reset(4'b0010, DATA_STD, 1'b1);
      push(1, DATA_STD);
      wait_dr(1, 30);
      req = 4'b1100;
      tick(10);
      req = 4'b1000;
      push(3, DATA_STD);
      wait_dr(2, 30);
      req = '0;
      tick(15);
      check("drop_ack_count", ack_cnt, 2);
      check("drop_ack_seen", 32'(ack_or), 32'(4'b1010));

      // reset asserted during WAIT aborts the frame asynchronously
      do_reset(4'b0001, DATA_STD, 1'b1);
      push(0, DATA_STD);
      wait_dr(1, 30);
      tick(3);
      #2 rstn = 1'b0;
      #1;
      check("midrst_d_ready", 32'(d_ready), 0);
      check("midrst_ack", 32'(ack), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_tx_en", 32'(tx_en), 0);
      check("midrst_grant_id", 32'(grant_id), 3);
      check("midrst_d_in", 32'(d_in), 0);
      req = 4'b0100;
      sb.delete();
      push(2, DATA_STD);
      ack_cnt = 0;
      dr_cnt  = 0;
      ack_or  = '0;
      tick(1);
      rstn = 1'b1;
      #1;
      check("post_rst_ack", 32'(ack), 32'(4'b0100));
      wait_dr(1, 30);
      req = '0;
      tick(15);
      check("post_rst_ack_count", ack_cnt, 1);
      check("post_rst_ack_seen", 32'(ack_or), 32'(4'b0100));
      check("post_rst_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per character.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 The block SHALL have parameter FRAME_CYCLES, default 11, meaning clocks the transmitter needs after a d_ready pulse before it accepts the next.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1, meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1, meaning scheduler enable; low blocks new grants.
REQ-007 The block SHALL have port req, input, NREQ, meaning per-requester request, level, held until ack.
REQ-008 The block SHALL have port req_data, input, NREQ*WIDTH, meaning requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port ack, output, NREQ, meaning one-cycle pulse to the requester whose data was taken.
REQ-010 The block SHALL have port d_in, output, WIDTH, meaning character to the transmitter.
REQ-011 The block SHALL have port d_ready, output, 1, meaning one-cycle load strobe to the transmitter.
REQ-012 The block SHALL have port tx_en, output, 1, meaning transmitter enable.
REQ-013 The block SHALL have port busy, output, 1, meaning high whenever state is not IDLE.
REQ-014 The block SHALL have port grant_id, output, clog2(NREQ), meaning index of the last granted requester.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and WAIT.
REQ-016 In IDLE with en=1 and req!=0, the block SHALL select a winner, register its req_data into d_in, pulse ack[winner] that same cycle, update grant_id and go to LOAD.
REQ-017 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with ack=0.
REQ-018 In LOAD, the block SHALL drive d_ready=1 for exactly one cycle, load the down-counter with FRAME_CYCLES-1 and go to WAIT.
REQ-019 In WAIT, the block SHALL decrement the counter each cycle and go to IDLE in the cycle after it reads 0.
REQ-020 With requests continuously pending, consecutive d_ready pulses SHALL be exactly FRAME_CYCLES+2 cycles apart (13 by default).
REQ-021 d_in SHALL hold its value from LOAD until the next grant.
REQ-022 Arbitration SHALL be round-robin: the search starts at grant_id+1 modulo NREQ, and the first set req bit wins.
REQ-023 At most one ack bit SHALL be high in any cycle, and ack SHALL be 0 outside the IDLE grant cycle.
REQ-024 A req deasserted before its ack SHALL be dropped silently, with no grant and no error.
REQ-025 en falling during LOAD or WAIT SHALL NOT abort the frame; the block SHALL finish WAIT and then stay in IDLE.
REQ-026 tx_en SHALL equal en OR busy.
REQ-027 The counter SHALL be clog2(FRAME_CYCLES) bits wide and SHALL never wrap below 0.

Reset
REQ-028 While rstn=0, the block SHALL asynchronously force state to IDLE, the counter to 0, d_in to 0, d_ready to 0, ack to 0, busy to 0, tx_en to 0 and grant_id to NREQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no d_ready pulse and no ack after release until a new grant.
REQ-030 After rstn rises, the first grant SHALL be possible on the first rising clock edge.

Configuration
REQ-031 When macro TX_SCHED_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority (lowest set index wins), and grant_id SHALL still report the winner.
REQ-032 When TX_SCHED_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-022, and all other behaviour SHALL be identical in both builds.

Verification
REQ-033 The bench SHALL apply reset, en=1, req=0001 with data0=0xA5 -> ack[0] pulses in the grant cycle, d_ready pulses the next cycle with d_in=0xA5, busy stays high for 12 cycles.
REQ-034 The bench SHALL hold req=1111 with data 0x10..0x13 -> four d_ready pulses 13 cycles apart, d_in order 0x10, 0x11, 0x12, 0x13, ack order 0, 1, 2, 3.
REQ-035 The bench SHALL hold req=1010 continuously -> grants alternate 1, 3, 1, 3; under TX_SCHED_FIXED_PRIO_EN, grants are 1, 1, 1, 1.
REQ-036 The bench SHALL drop en 3 cycles after d_ready while req=0001 is held -> the frame completes, no further ack or d_ready appears, and grants resume after en returns to 1.
REQ-037 The bench SHALL assert rstn=0 during WAIT -> d_ready, ack and busy go to 0 asynchronously, and after release req=0100 is granted with d_ready following the grant cycle by 1 clock.
REQ-038 The bench SHALL drop req[2] one cycle before its possible grant while req[3] is held -> requester 3 is granted and ack[2] never pulses.
